// File: rtl/nmcu_mem_arbiter.sv
// Round-robin arbiter that shares one external memory port among NUM_NMCUS
// near-memory compute units; one transaction in flight, all outputs registered.
module nmcu_mem_arbiter #(
   parameter int NUM_NMCUS     = 4,
   parameter int ADDR_WIDTH    = 16,
   parameter int DATABUS_WIDTH = 32
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_NMCUS-1:0]                     req_sel,
   input  logic [NUM_NMCUS-1:0]                     req_w,
   input  logic [NUM_NMCUS-1:0][ADDR_WIDTH-1:0]     req_addr,
   input  logic [NUM_NMCUS-1:0][DATABUS_WIDTH-1:0]  req_wdata,
   output logic [NUM_NMCUS-1:0]                     req_ready,
   output logic [DATABUS_WIDTH-1:0]                 req_rdata,
   output logic [NUM_NMCUS-1:0]                     grant,
   output logic                                     busy,
   output logic                                     mem_sel,
   output logic                                     mem_w,
   output logic [ADDR_WIDTH-1:0]                    mem_addr,
   output logic [DATABUS_WIDTH-1:0]                 mem_wdata,
   input  logic                                     mem_ready,
   input  logic [DATABUS_WIDTH-1:0]                 mem_rdata
);
   localparam int IDX_W = $clog2(NUM_NMCUS);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t                     r_state, w_state_next;
   logic [IDX_W-1:0]           r_rr_ptr, w_rr_ptr_next;
   logic [IDX_W-1:0]           r_grant_idx, w_grant_idx_next;
   logic [NUM_NMCUS-1:0]       r_grant, w_grant_next;
   logic [NUM_NMCUS-1:0]       r_req_ready, w_req_ready_next;
   logic [DATABUS_WIDTH-1:0]   r_req_rdata, w_req_rdata_next;
   logic                       r_busy, w_busy_next;
   logic                       r_mem_sel, w_mem_sel_next;
   logic                       r_mem_w, w_mem_w_next;
   logic [ADDR_WIDTH-1:0]      r_addr, w_addr_next;
   logic [DATABUS_WIDTH-1:0]   r_wdata, w_wdata_next;

   logic                       w_found;
   logic [IDX_W-1:0]           w_win;
   int                         w_cand;

   // Rotating priority scan starting at the pointer; first active index wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = 0;
      for (int i = 0; i < NUM_NMCUS; i++) begin
         w_cand = int'(r_rr_ptr) + i;
         if (w_cand >= NUM_NMCUS) w_cand = w_cand - NUM_NMCUS;
         if (!w_found && req_sel[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_rr_ptr_next    = r_rr_ptr;
      w_grant_idx_next = r_grant_idx;
      w_grant_next     = r_grant;
      w_req_ready_next = '0;
      w_req_rdata_next = r_req_rdata;
      w_busy_next      = r_busy;
      w_mem_sel_next   = r_mem_sel;
      w_mem_w_next     = r_mem_w;
      w_addr_next      = r_addr;
      w_wdata_next     = r_wdata;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_grant_idx_next      = w_win;
               w_grant_next          = '0;
               w_grant_next[w_win]   = 1'b1;
               w_mem_sel_next        = 1'b1;
               w_mem_w_next          = req_w[w_win];
               w_addr_next           = req_addr[w_win];
               w_wdata_next          = req_wdata[w_win];
               w_busy_next           = 1'b1;
               w_state_next          = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (mem_ready) begin
               w_req_rdata_next              = mem_rdata;
               w_mem_sel_next                = 1'b0;
               w_mem_w_next                  = 1'b0;
               w_req_ready_next[r_grant_idx] = 1'b1;
               w_state_next                  = S_RESP;
            end
         end
         S_RESP: begin
            // Explicit wrap so non-power-of-two counts never reach an invalid index.
            if (r_grant_idx == IDX_W'(NUM_NMCUS - 1))
               w_rr_ptr_next = '0;
            else
               w_rr_ptr_next = r_grant_idx + IDX_W'(1);
            w_grant_next = '0;
            w_busy_next  = 1'b0;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= '0;
         r_grant_idx <= '0;
         r_grant     <= '0;
         r_req_ready <= '0;
         r_req_rdata <= '0;
         r_busy      <= 1'b0;
         r_mem_sel   <= 1'b0;
         r_mem_w     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
      end else begin
         r_state     <= w_state_next;
         r_rr_ptr    <= w_rr_ptr_next;
         r_grant_idx <= w_grant_idx_next;
         r_grant     <= w_grant_next;
         r_req_ready <= w_req_ready_next;
         r_req_rdata <= w_req_rdata_next;
         r_busy      <= w_busy_next;
         r_mem_sel   <= w_mem_sel_next;
         r_mem_w     <= w_mem_w_next;
         r_addr      <= w_addr_next;
         r_wdata     <= w_wdata_next;
      end
   end

   assign req_ready = r_req_ready;
   assign req_rdata = r_req_rdata;
   assign grant     = r_grant;
   assign busy      = r_busy;
   assign mem_sel   = r_mem_sel;
   assign mem_w     = r_mem_w;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_nmcu_mem_arbiter.sv
// Directed bench for nmcu_mem_arbiter: a 4-requester instance plus a
// 3-requester instance for pointer wrap on a non-power-of-two count.
module tb_nmcu_mem_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [3:0]        req_sel, req_w, req_ready, grant;
   logic [3:0][15:0]  req_addr;
   logic [3:0][31:0]  req_wdata;
   logic [31:0]       req_rdata, mem_wdata, mem_rdata;
   logic              busy, mem_sel, mem_w, mem_ready;
   logic [15:0]       mem_addr;

   logic [2:0]        req_sel3, req_ready3, grant3;
   logic [2:0]        req_w3;
   logic [2:0][15:0]  req_addr3;
   logic [2:0][31:0]  req_wdata3;
   logic [31:0]       req_rdata3, mem_wdata3;
   logic              busy3, mem_sel3, mem_w3, mem_ready3;
   logic [15:0]       mem_addr3;

   // Memory model: ready after wait_cfg extra cycles of mem_sel.
   int wait_cfg = 0;
   int sel_cnt  = 0;
   always @(posedge clk) begin
      if (!mem_sel) sel_cnt <= 0;
      else          sel_cnt <= sel_cnt + 1;
   end
   assign mem_ready  = mem_sel && (sel_cnt >= wait_cfg);
   assign mem_ready3 = mem_sel3;

   localparam logic [3:0] RR_ORDER [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   nmcu_mem_arbiter #(.NUM_NMCUS(4), .ADDR_WIDTH(16), .DATABUS_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .req_sel(req_sel), .req_w(req_w), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .req_rdata(req_rdata), .grant(grant),
      .busy(busy), .mem_sel(mem_sel), .mem_w(mem_w), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   nmcu_mem_arbiter #(.NUM_NMCUS(3), .ADDR_WIDTH(16), .DATABUS_WIDTH(32)) dut3 (
      .clk(clk), .rst(rst), .req_sel(req_sel3), .req_w(req_w3), .req_addr(req_addr3),
      .req_wdata(req_wdata3), .req_ready(req_ready3), .req_rdata(req_rdata3), .grant(grant3),
      .busy(busy3), .mem_sel(mem_sel3), .mem_w(mem_w3), .mem_addr(mem_addr3),
      .mem_wdata(mem_wdata3), .mem_ready(mem_ready3), .mem_rdata(32'h0)
   );

   task automatic wait_grant(output logic [3:0] g);
      g = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (grant != 0) begin g = grant; break; end
      end
   endtask

   task automatic wait_ready(output logic [3:0] r);
      r = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (req_ready != 0) begin r = req_ready; break; end
      end
   endtask

   task automatic wait_grant3(output logic [2:0] g);
      g = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (grant3 != 0) begin g = grant3; break; end
      end
   endtask

   task automatic wait_ready3(output logic [2:0] r);
      r = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (req_ready3 != 0) begin r = req_ready3; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({grant, req_ready, busy, mem_sel, mem_w} !== 11'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 0", {grant, req_ready, busy, mem_sel, mem_w});
      end
      checks++;
      if ({mem_addr, mem_wdata, req_rdata} !== 80'h0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, req_rdata});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_read;
      logic [3:0] g, r;
      wait_cfg    = 0;
      mem_rdata   = 32'hDEADBEEF;
      req_w       = 4'b0000;
      req_addr[2] = 16'h0040;
      req_sel     = 4'b0100;
      @(negedge clk);
      checks++;
      if ({mem_sel, mem_w, mem_addr, grant, busy} !== {1'b1, 1'b0, 16'h0040, 4'b0100, 1'b1}) begin
         errors++;
         $display("FAIL read_access: got sel=%b w=%b addr=%h grant=%b busy=%b expected 1 0 0040 0100 1",
                  mem_sel, mem_w, mem_addr, grant, busy);
      end
      @(negedge clk);
      checks++;
      if ({req_ready, req_rdata, mem_sel} !== {4'b0100, 32'hDEADBEEF, 1'b0}) begin
         errors++;
         $display("FAIL read_resp: got ready=%b rdata=%h sel=%b expected 0100 deadbeef 0",
                  req_ready, req_rdata, mem_sel);
      end
      req_sel   = 4'b0000;
      mem_rdata = 32'h0;
      @(negedge clk);
      checks++;
      if ({req_ready, grant, busy, req_rdata} !== {4'b0, 4'b0, 1'b0, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL read_idle: got ready=%b grant=%b busy=%b rdata=%h expected 0 0 0 deadbeef",
                  req_ready, grant, busy, req_rdata);
      end
      // Pointer should now be 3, so requester 3 beats requester 0.
      req_sel = 4'b1001;
      wait_grant(g);
      checks++;
      if (g !== 4'b1000) begin
         errors++;
         $display("FAIL ptr_after_read: got grant %b expected 1000", g);
      end
      wait_ready(r);
      req_sel = 4'b0000;
      checks++;
      if (r !== 4'b1000) begin
         errors++;
         $display("FAIL ptr_after_read_ready: got %b expected 1000", r);
      end
      @(negedge clk);
   endtask

   task automatic test_write_wait;
      wait_cfg     = 4;
      req_w        = 4'b0010;
      req_addr[1]  = 16'h0100;
      req_wdata[1] = 32'h12345678;
      req_sel      = 4'b0010;
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({mem_sel, mem_w, mem_addr, mem_wdata, req_ready} !==
             {1'b1, 1'b1, 16'h0100, 32'h12345678, 4'b0}) begin
            errors++;
            $display("FAIL write_hold[%0d]: got sel=%b w=%b addr=%h wdata=%h ready=%b expected 1 1 0100 12345678 0",
                     c, mem_sel, mem_w, mem_addr, mem_wdata, req_ready);
         end
         @(negedge clk);
      end
      checks++;
      if ({req_ready, mem_sel, mem_w} !== {4'b0010, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL write_resp: got ready=%b sel=%b w=%b expected 0010 0 0", req_ready, mem_sel, mem_w);
      end
      req_sel = 4'b0000;
      req_w   = 4'b0000;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL write_single_pulse: got %b expected 0000", req_ready);
      end
   endtask

   task automatic test_mid_change;
      logic [3:0] r;
      wait_cfg    = 2;
      req_w       = 4'b0000;
      req_addr[0] = 16'h0A0A;
      req_sel     = 4'b0001;
      @(negedge clk);
      checks++;
      if ({mem_sel, mem_addr, grant} !== {1'b1, 16'h0A0A, 4'b0001}) begin
         errors++;
         $display("FAIL mid_first: got sel=%b addr=%h grant=%b expected 1 0a0a 0001", mem_sel, mem_addr, grant);
      end
      req_addr[0] = 16'hFFFF;
      req_w       = 4'b0001;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if ({mem_sel, mem_w, mem_addr} !== {1'b1, 1'b0, 16'h0A0A}) begin
            errors++;
            $display("FAIL mid_hold[%0d]: got sel=%b w=%b addr=%h expected 1 0 0a0a", c, mem_sel, mem_w, mem_addr);
         end
      end
      wait_ready(r);
      req_sel = 4'b0000;
      req_w   = 4'b0000;
      checks++;
      if (r !== 4'b0001) begin
         errors++;
         $display("FAIL mid_ready: got %b expected 0001", r);
      end
      @(negedge clk);
   endtask

   task automatic test_round_robin;
      logic [3:0] prev_g, r;
      int k, low_run;
      bit seen_sel;
      rst = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      wait_cfg = 0;
      req_sel  = 4'b1111;
      prev_g   = '0;
      k        = 0;
      low_run  = 0;
      seen_sel = 1'b0;
      for (int c = 0; c < 60 && k < 5; c++) begin
         @(negedge clk);
         if (grant != 0 && prev_g == 0) begin
            checks++;
            if (grant !== RR_ORDER[k]) begin
               errors++;
               $display("FAIL rr_order[%0d]: got %b expected %b", k, grant, RR_ORDER[k]);
            end
            k++;
         end
         if (grant != 0) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL rr_busy: got %b expected 1 (grant %b)", busy, grant);
            end
         end
         if (mem_sel) begin
            if (seen_sel && low_run > 0) begin
               checks++;
               if (low_run < 2) begin
                  errors++;
                  $display("FAIL rr_gap: got %0d low cycles expected >=2", low_run);
               end
            end
            low_run  = 0;
            seen_sel = 1'b1;
         end else begin
            low_run++;
         end
         prev_g = grant;
      end
      checks++;
      if (k != 5) begin
         errors++;
         $display("FAIL rr_count: got %0d grants expected 5", k);
      end
      req_sel = 4'b0000;
      wait_ready(r);
      @(negedge clk);
   endtask

   task automatic test_wrap_n3;
      logic [2:0] g, r;
      req_sel3 = 3'b010;
      wait_ready3(r);
      req_sel3 = 3'b000;
      checks++;
      if (r !== 3'b010) begin
         errors++;
         $display("FAIL wrap_setup: got %b expected 010", r);
      end
      @(negedge clk);
      req_sel3 = 3'b101;
      wait_grant3(g);
      checks++;
      if (g !== 3'b100) begin
         errors++;
         $display("FAIL wrap_first: got %b expected 100", g);
      end
      wait_ready3(r);
      req_sel3 = 3'b001;
      @(negedge clk);
      wait_grant3(g);
      checks++;
      if (g !== 3'b001) begin
         errors++;
         $display("FAIL wrap_second: got %b expected 001", g);
      end
      wait_ready3(r);
      req_sel3 = 3'b110;
      @(negedge clk);
      wait_grant3(g);
      checks++;
      if (g !== 3'b010) begin
         errors++;
         $display("FAIL wrap_third: got %b expected 010", g);
      end
      wait_ready3(r);
      req_sel3 = 3'b000;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      logic [3:0] g, r;
      wait_cfg = 100;
      req_sel  = 4'b0100;
      wait_grant(g);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      req_sel = 4'b0000;
      checks++;
      if ({mem_sel, grant, busy, req_ready} !== 10'b0) begin
         errors++;
         $display("FAIL rstmid_state: got sel=%b grant=%b busy=%b ready=%b expected all 0",
                  mem_sel, grant, busy, req_ready);
      end
      wait_cfg = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_no_ready[%0d]: got %b expected 0000", c, req_ready);
         end
      end
      // Pointer back at 0: requester 0 wins over 1.
      req_sel = 4'b0011;
      wait_grant(g);
      checks++;
      if (g !== 4'b0001) begin
         errors++;
         $display("FAIL rstmid_ptr: got grant %b expected 0001", g);
      end
      wait_ready(r);
      req_sel = 4'b0010;
      checks++;
      if (r !== 4'b0001) begin
         errors++;
         $display("FAIL rstmid_ready0: got %b expected 0001", r);
      end
      wait_ready(r);
      req_sel = 4'b0000;
      checks++;
      if (r !== 4'b0010) begin
         errors++;
         $display("FAIL rstmid_ready1: got %b expected 0010", r);
      end
      @(negedge clk);
   endtask

   initial begin
      rst        = 1'b1;
      req_sel    = '0;
      req_w      = '0;
      req_addr   = '0;
      req_wdata  = '0;
      mem_rdata  = '0;
      req_sel3   = '0;
      req_w3     = '0;
      req_addr3  = '0;
      req_wdata3 = '0;
      @(negedge clk);
      test_reset();
      test_single_read();
      test_write_wait();
      test_mid_change();
      test_round_robin();
      test_wrap_n3();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/nmcu_mem_arbiter.md
# nmcu_mem_arbiter

Round-robin arbiter that shares the single external memory port among `NUM_NMCUS` near-memory compute units. It sits between the NMCU array and the memory interface. It serialises read and write requests using the existing sel/w/ready handshake, and guarantees that no requester waits more than `NUM_NMCUS` transactions. Only one transaction is in flight at a time, and the memory sees a `mem_sel` low gap between consecutive accesses.

## Interface
- `NUM_NMCUS`, default 4: number of requesters; must be ≥2; need not be a power of two.
- `ADDR_WIDTH`, default 16: address width.
- `DATABUS_WIDTH`, default 32: data width.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_sel`  in  `NUM_NMCUS`  per-requester request valid.
- `req_w`  in  `NUM_NMCUS`  per-requester direction: 1 = write, 0 = read.
- `req_addr`  in  `NUM_NMCUS` x `ADDR_WIDTH`  per-requester address.
- `req_wdata`  in  `NUM_NMCUS` x `DATABUS_WIDTH`  per-requester write data.
- `req_ready`  out  `NUM_NMCUS`  one-hot, one-cycle completion pulse to the granted requester.
- `req_rdata`  out  `DATABUS_WIDTH`  read data, shared by all requesters; valid while `req_ready` is high.
- `grant`  out  `NUM_NMCUS`  one-hot current owner; all zeros when idle.
- `busy`  out  1  high in ACCESS and RESP.
- `mem_sel`  out  1  memory select.
- `mem_w`  out  1  memory write enable.
- `mem_addr`  out  `ADDR_WIDTH`  memory address.
- `mem_wdata`  out  `DATABUS_WIDTH`  memory write data.
- `mem_ready`  in  1  memory done; sampled only while `mem_sel` = 1.
- `mem_rdata`  in  `DATABUS_WIDTH`  memory read data; valid with `mem_ready`.

## Operation
- **State machine:** IDLE, ACCESS, RESP. All outputs are registered.
- **Round-robin pointer:** `rr_ptr`, `$clog2(NUM_NMCUS)` bits. Increment wraps explicitly to 0 after `NUM_NMCUS-1`; do not rely on natural overflow.
- **IDLE:**
  - Scan requesters in order `rr_ptr`, `rr_ptr+1`, … (mod N). The first index with `req_sel` = 1 wins.
  - Latch the winner's index, `req_w`, `req_addr` and `req_wdata` into holding registers.
  - Set `grant` and go to ACCESS.
  - If no `req_sel` bit is set, stay in IDLE.
- **ACCESS:**
  - `mem_sel` = 1; `mem_w`, `mem_addr` and `mem_wdata` come from the holding registers.
  - Requester inputs are ignored after the latch, so changes to them mid-transaction have no effect.
  - On `mem_ready` = 1: capture `mem_rdata` into `req_rdata` (read or write), clear `mem_sel`/`mem_w`, go to RESP.
  - There is no timeout; ACCESS waits indefinitely.
- **RESP:**
  - `req_ready[grant_idx]` = 1 for exactly this cycle.
  - Set `rr_ptr` to `grant_idx+1` mod N; clear `grant`; return to IDLE.
- **Requester obligation:** drop `req_sel` in the cycle after `req_ready`. A `req_sel` still high in the following IDLE is treated as a new request, behind the pointer.
- **Simultaneous requests:** winner is chosen strictly by pointer order. A newly arriving request never preempts an in-flight transaction.
- **Fairness:** a continuously asserted requester is granted within `NUM_NMCUS` transactions.
- **`req_rdata`:** holds its last value until the next RESP.

## Timing
- **Reset values:**
  - state IDLE; `rr_ptr` = 0.
  - `grant`, `req_ready` = 0; `busy`, `mem_sel`, `mem_w` = 0.
  - `mem_addr`, `mem_wdata`, `req_rdata` = 0.
- **Reset mid-transaction:** abandon the transaction; `mem_sel` = 0 in the cycle after reset is sampled; no `req_ready` is issued.
- **Latency:**
  - `req_sel` is sampled in cycle 0 (IDLE); `mem_sel` is high in cycle 1.
  - If `mem_ready` is first high in cycle k (k ≥ 1), `req_ready` is high in cycle k+1.
  - Fastest path (ready in cycle 1): 3 cycles of occupancy (IDLE→ACCESS→RESP).
- **Gap:** `mem_sel` is low in RESP and IDLE. Back-to-back grants are therefore at least 3 cycles apart, with 2 cycles of `mem_sel` low between them.
- **`mem_ready` outside ACCESS:** ignored.

## Test plan
- **Single read:** reset; `req_sel[2]` = 1, `req_w` = 0, `req_addr[2]` = 0x0040; memory returns 0xDEADBEEF with ready in the first ACCESS cycle.
  - → `mem_addr` = 0x0040, `mem_w` = 0 in cycle 1.
  - → `req_ready` = 4'b0100 and `req_rdata` = 0xDEADBEEF in cycle 2.
  - → `rr_ptr` = 3.
- **Write with wait states:** `req_sel[1]`, `req_w[1]` = 1, `req_wdata` = 0x12345678, `req_addr` = 0x0100; `mem_ready` delayed 4 cycles.
  - → `mem_sel`/`mem_w` held 5 cycles with stable address/data.
  - → single `req_ready[1]` pulse one cycle after `mem_ready`.
- **All four requesting continuously from reset:** → grant order 0, 1, 2, 3, 0.
  - → `busy` high throughout each transaction.
  - → `mem_sel` low for ≥2 cycles between accesses.
- **Wrap with `NUM_NMCUS` = 3:** requesters 0 and 2 active, pointer at 2.
  - → grant 2, then 0.
  - → `rr_ptr` never equals 3.
- **Mid-transaction input change:** `req_addr` changes during ACCESS → `mem_addr` keeps the latched value.
- **Reset mid-transaction:** `rst` asserted during ACCESS.
  - → next cycle `mem_sel` = 0, `grant` = 0, `rr_ptr` = 0.
  - → no `req_ready` pulse.
  - → a request after reset completes normally.
